// File: rtl/query_stream_dispatcher_if.sv
// Stream-side and engine-side handshake bundle of the query stream dispatcher.
interface query_stream_dispatcher_if #(
  parameter int unsigned NUM_PES      = 64,
  parameter int unsigned NUM_ENGINES  = 4,
  parameter int unsigned STREAM_WIDTH = 128
);
  localparam int unsigned BLOCK_W = 2 * NUM_PES;

  logic                    in_valid;
  logic [STREAM_WIDTH-1:0] in_data;
  logic                    in_rdy;

  logic [24:0]             ref_length_out;
  logic [24:0]             ref_addr_out;
  logic [15:0]             num_query_blocks_out;
  logic [NUM_ENGINES-1:0]  query_info_valid_out;
  logic [NUM_ENGINES-1:0]  query_info_rdy_in;

  logic [BLOCK_W-1:0]      query_seq_block_out;
  logic [NUM_ENGINES-1:0]  query_seq_block_valid_out;
  logic [NUM_ENGINES-1:0]  query_seq_block_rdy_in;

  logic                    err_bad_engine;
  logic [15:0]             drop_count;
  logic [31:0]             pkt_count;
  logic                    busy;

  // master: the dispatcher; slave: stream FIFO plus engines
  modport master (
    input  in_valid, in_data, query_info_rdy_in, query_seq_block_rdy_in,
    output in_rdy, ref_length_out, ref_addr_out, num_query_blocks_out,
           query_info_valid_out, query_seq_block_out, query_seq_block_valid_out,
           err_bad_engine, drop_count, pkt_count, busy
  );

  modport slave (
    output in_valid, in_data, query_info_rdy_in, query_seq_block_rdy_in,
    input  in_rdy, ref_length_out, ref_addr_out, num_query_blocks_out,
           query_info_valid_out, query_seq_block_out, query_seq_block_valid_out,
           err_bad_engine, drop_count, pkt_count, busy
  );
endinterface

// File: rtl/query_stream_dispatcher.sv
// Parses the synchronized query stream into header + block packets and
// dispatches each packet to one alignment engine (round-robin or directed).
module query_stream_dispatcher #(
  parameter int unsigned NUM_PES      = 64,
  parameter int unsigned NUM_ENGINES  = 4,
  parameter int unsigned STREAM_WIDTH = 128,
  parameter int unsigned DIRECTED     = 0
) (
  input logic                clk,
  input logic                rst,
  query_stream_dispatcher_if.master bus
);
  localparam int unsigned SEL_W = 8;
  localparam int unsigned CNT_W = 16;
  localparam logic [SEL_W-1:0] LAST_ENG = SEL_W'(NUM_ENGINES - 1);

  typedef enum logic [1:0] {IDLE, INFO, BLOCKS, DROP} state_t;

  state_t                 state_q, state_d;
  logic [SEL_W-1:0]       sel_q, rr_ptr_q, hdr_sel;
  logic [CNT_W-1:0]       remaining_q, hdr_blocks, num_blocks_q;
  logic [24:0]            ref_length_q, ref_addr_q;
  logic                   armed_q, err_q;
  logic [15:0]            drop_count_q;
  logic [31:0]            pkt_count_q;
  logic [NUM_ENGINES-1:0] sel_oh;
  logic                   sel_info_rdy, sel_block_rdy, hdr_bad;
  logic                   accept, load_info, dec_rem, pkt_done;

  assign hdr_blocks = bus.in_data[79:64];
  assign hdr_sel    = (DIRECTED != 0) ? bus.in_data[87:80] : rr_ptr_q;
  assign hdr_bad    = (DIRECTED != 0) && (32'(hdr_sel) >= NUM_ENGINES);

  // Decoded engine select; ready from non-selected engines is masked off.
  always_comb begin
    for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
      sel_oh[i] = (sel_q == SEL_W'(i));
    end
  end

  assign sel_info_rdy  = |(bus.query_info_rdy_in & sel_oh);
  assign sel_block_rdy = |(bus.query_seq_block_rdy_in & sel_oh);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d                       = state_q;
    bus.in_rdy                    = 1'b0;
    bus.query_info_valid_out      = '0;
    bus.query_seq_block_valid_out = '0;
    accept                        = 1'b0;
    load_info                     = 1'b0;
    dec_rem                       = 1'b0;
    pkt_done                      = 1'b0;
    case (state_q)
      IDLE: begin
        // armed_q keeps in_rdy low until the first clock after reset
        bus.in_rdy = armed_q;
        if (bus.in_valid && armed_q) begin
          accept = 1'b1;
          if (hdr_bad) state_d = (hdr_blocks == '0) ? IDLE : DROP;
          else         state_d = INFO;
        end
      end
      INFO: begin
        bus.query_info_valid_out = sel_oh;
        if (sel_info_rdy) begin
          load_info = 1'b1;
          if (num_blocks_q == '0) begin
            pkt_done = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d  = BLOCKS;
          end
        end
      end
      BLOCKS: begin
        bus.query_seq_block_valid_out = bus.in_valid ? sel_oh : '0;
        bus.in_rdy                    = sel_block_rdy;
        if (bus.in_valid && sel_block_rdy) begin
          dec_rem = 1'b1;
          if (remaining_q == CNT_W'(1)) begin
            pkt_done = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      DROP: begin
        bus.in_rdy = 1'b1;
        if (bus.in_valid) begin
          dec_rem = 1'b1;
          if (remaining_q == CNT_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_q      <= 1'b0;
      err_q        <= 1'b0;
      sel_q        <= '0;
      rr_ptr_q     <= '0;
      remaining_q  <= '0;
      ref_length_q <= '0;
      ref_addr_q   <= '0;
      num_blocks_q <= '0;
      drop_count_q <= '0;
      pkt_count_q  <= '0;
    end else begin
      armed_q <= 1'b1;
      err_q   <= accept && hdr_bad;
      if (accept) begin
        sel_q        <= hdr_sel;
        ref_length_q <= bus.in_data[24:0];
        ref_addr_q   <= bus.in_data[56:32];
        num_blocks_q <= hdr_blocks;
        if (hdr_bad) begin
          remaining_q <= hdr_blocks;
          if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
        end
      end
      if (load_info) remaining_q <= num_blocks_q;
      if (dec_rem)   remaining_q <= remaining_q - CNT_W'(1);
      // Round-robin pointer moves only when a packet really completes.
      if (pkt_done) begin
        pkt_count_q <= pkt_count_q + 32'd1;
        rr_ptr_q    <= (rr_ptr_q == LAST_ENG) ? '0 : rr_ptr_q + SEL_W'(1);
      end
    end
  end

  assign bus.ref_length_out       = ref_length_q;
  assign bus.ref_addr_out         = ref_addr_q;
  assign bus.num_query_blocks_out = num_blocks_q;
  assign bus.query_seq_block_out  = bus.in_data[2*NUM_PES-1:0];
  assign bus.err_bad_engine       = err_q;
  assign bus.drop_count           = drop_count_q;
  assign bus.pkt_count            = pkt_count_q;
  assign bus.busy                 = (state_q != IDLE);
endmodule

// File: tb/tb_query_stream_dispatcher.sv
// Bench for query_stream_dispatcher: one round-robin and one directed instance
// fed from queue FIFOs and checked against a transaction-level scoreboard.
module tb_query_stream_dispatcher;
  localparam int unsigned NE = 4;
  localparam int unsigned NP = 64;
  localparam int unsigned SW = 128;
  localparam int unsigned BW = 2 * NP;

  typedef logic [SW-1:0] word_t;
  typedef struct packed {
    logic          is_info;
    logic [7:0]    eng;
    logic [24:0]   rl;
    logic [24:0]   ra;
    logic [15:0]   nb;
    logic [BW-1:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_v   [2];
  word_t         in_d   [2];
  logic          in_r   [2];
  logic [NE-1:0] info_v [2];
  logic [NE-1:0] info_r [2];
  logic [NE-1:0] blk_v  [2];
  logic [NE-1:0] blk_r  [2];
  logic [BW-1:0] blk_d  [2];
  logic [24:0]   rl     [2];
  logic [24:0]   ra     [2];
  logic [15:0]   nb     [2];
  logic [15:0]   dc     [2];
  logic [31:0]   pc     [2];
  logic          err    [2];
  logic          bsy    [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    query_stream_dispatcher_if #(.NUM_PES(NP), .NUM_ENGINES(NE), .STREAM_WIDTH(SW)) bus ();
    query_stream_dispatcher #(
      .NUM_PES(NP), .NUM_ENGINES(NE), .STREAM_WIDTH(SW), .DIRECTED(g)
    ) u_dut (.clk(clk), .rst(rst), .bus(bus));
    assign bus.in_valid               = in_v[g];
    assign bus.in_data                = in_d[g];
    assign bus.query_info_rdy_in      = info_r[g];
    assign bus.query_seq_block_rdy_in = blk_r[g];
    assign in_r[g]   = bus.in_rdy;
    assign info_v[g] = bus.query_info_valid_out;
    assign blk_v[g]  = bus.query_seq_block_valid_out;
    assign blk_d[g]  = bus.query_seq_block_out;
    assign rl[g]     = bus.ref_length_out;
    assign ra[g]     = bus.ref_addr_out;
    assign nb[g]     = bus.num_query_blocks_out;
    assign dc[g]     = bus.drop_count;
    assign pc[g]     = bus.pkt_count;
    assign err[g]    = bus.err_bad_engine;
    assign bsy[g]    = bus.busy;
  end

  word_t fifo  [2][$];
  ev_t   exp_q [2][$];
  int    rr_model [2];
  int    exp_pkt  [2];
  int    drops    [2];
  int    err_cnt  [2];
  int    rdy_mode [2];
  logic  toggle;
  int    vectors = 0;
  int    miscompares = 0;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      fifo[d].delete();
      exp_q[d].delete();
      rr_model[d] = 0;
      exp_pkt[d]  = 0;
      drops[d]    = 0;
      err_cnt[d]  = 0;
    end
  endtask

  // Queue one packet into the stream and record what the engines must see.
  task automatic push_pkt(input int d, input logic [7:0] field, input logic [15:0] blocks);
    word_t w;
    ev_t   e;
    logic  bad;
    w = {$urandom, $urandom, $urandom, $urandom};
    w[87:80] = field;
    w[79:64] = blocks;
    fifo[d].push_back(w);
    bad = (d == 1) && (int'(field) >= int'(NE));
    e = '0;
    e.is_info = 1'b1;
    e.eng = (d == 1) ? field : 8'(rr_model[d]);
    e.rl = w[24:0];
    e.ra = w[56:32];
    e.nb = blocks;
    if (bad) drops[d]++;
    else begin
      exp_q[d].push_back(e);
      exp_pkt[d]++;
      if (d == 0) rr_model[d] = (rr_model[d] + 1) % int'(NE);
    end
    e.is_info = 1'b0;
    for (int b = 0; b < int'(blocks); b++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      fifo[d].push_back(w);
      e.data = w[BW-1:0];
      if (!bad) exp_q[d].push_back(e);
    end
  endtask

  task automatic check_cycle(input int d);
    ev_t   h;
    logic  have;
    word_t w;
    have = (exp_q[d].size() != 0);
    h = have ? exp_q[d][0] : '0;
    if (info_v[d] != '0) begin
      chk("info_expected", {have, h.is_info}, 2'b11);
      chk("info_engine", info_v[d], NE'(1) << h.eng);
      chk("info_header", {rl[d], ra[d], nb[d]}, {h.rl, h.ra, h.nb});
      chk("info_in_rdy", in_r[d], 1'b0);
      if (|(info_v[d] & info_r[d]) && have) void'(exp_q[d].pop_front());
    end
    if (blk_v[d] != '0) begin
      chk("blk_expected", {have, h.is_info}, 2'b10);
      chk("blk_engine", blk_v[d], NE'(1) << h.eng);
      chk("blk_data", blk_d[d], h.data);
      chk("blk_src_valid", in_v[d], 1'b1);
      chk("blk_in_rdy", in_r[d], |(blk_r[d] & blk_v[d]));
      if (in_v[d] && in_r[d] && have) void'(exp_q[d].pop_front());
    end
    if (in_v[d] && in_r[d]) w = fifo[d].pop_front();
    if (err[d]) err_cnt[d]++;
  endtask

  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      in_v[d] = (fifo[d].size() != 0);
      in_d[d] = in_v[d] ? fifo[d][0] : '0;
      case (rdy_mode[d])
        1:       begin info_r[d] = NE'($urandom); blk_r[d] = NE'($urandom); end
        2:       begin info_r[d] = '0;            blk_r[d] = '1;            end
        3:       begin info_r[d] = '1; blk_r[d] = NE'($urandom); blk_r[d][2] = toggle; end
        default: begin info_r[d] = '1;            blk_r[d] = '1;            end
      endcase
    end
    toggle = ~toggle;
    @(negedge clk);
    for (int d = 0; d < 2; d++) check_cycle(d);
    @(posedge clk);
    #1;
  endtask

  task automatic run_idle(input string tag, input int budget);
    logic done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      tick();
      done = fifo[0].size() == 0 && fifo[1].size() == 0 && exp_q[0].size() == 0 &&
             exp_q[1].size() == 0 && !bsy[0] && !bsy[1];
    end
    chk(tag, done, 1'b1);
  endtask

  task automatic check_reset(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_valids"}, {info_v[d], blk_v[d]}, '0);
      chk({tag, "_ctrl"}, {in_r[d], err[d], bsy[d]}, '0);
      chk({tag, "_counts"}, {dc[d], pc[d]}, '0);
      chk({tag, "_header"}, {rl[d], ra[d], nb[d]}, '0);
    end
  endtask

  task automatic final_counts(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_pkt_count"}, pc[d], 32'(exp_pkt[d]));
      chk({tag, "_drop_count"}, dc[d], 16'(drops[d]));
      chk({tag, "_err_pulses"}, 32'(err_cnt[d]), 32'(drops[d]));
    end
  endtask

  initial begin
    int e_eng;
    toggle = 1'b1;
    rdy_mode[0] = 0;
    rdy_mode[1] = 0;
    for (int d = 0; d < 2; d++) begin
      in_v[d] = 1'b0; in_d[d] = '0; info_r[d] = '0; blk_r[d] = '0;
    end
    model_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;

    // Round-robin over four engines, two blocks each.
    for (int p = 0; p < 4; p++) push_pkt(0, 8'h00, 16'd2);
    run_idle("t1_drain", 200);
    chk("t1_pkt_count", pc[0], 32'd4);

    // Zero-block packets still rotate the pointer.
    push_pkt(0, 8'h00, 16'd0);
    push_pkt(0, 8'h00, 16'd0);
    run_idle("t2_drain", 100);
    chk("t2_pkt_count", pc[0], 32'd6);

    // Directed to engine 2 with a toggling block ready.
    rdy_mode[1] = 3;
    push_pkt(1, 8'd2, 16'd3);
    run_idle("t3_drain", 100);
    chk("t3_pkt_count", pc[1], 32'd1);
    rdy_mode[1] = 0;

    // Nonexistent engine: packet swallowed, next packet dispatched.
    push_pkt(1, 8'd9, 16'd5);
    push_pkt(1, 8'd1, 16'd1);
    run_idle("t4_drain", 100);
    chk("t4_drop_count", dc[1], 16'd1);
    chk("t4_err_pulses", 32'(err_cnt[1]), 32'd1);
    chk("t4_pkt_count", pc[1], 32'd2);

    // Info ready withheld: header held stable and stream paused.
    e_eng = rr_model[0];
    rdy_mode[0] = 2;
    push_pkt(0, 8'h00, 16'd1);
    tick();
    chk("t5_latency", info_v[0], NE'(1) << e_eng);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("t5_info_hold", info_v[0], NE'(1) << e_eng);
      chk("t5_in_rdy", in_r[0], 1'b0);
    end
    rdy_mode[0] = 0;
    run_idle("t5_drain", 100);
    chk("t5_pkt_count", pc[0], 32'd7);

    // Randomized traffic with random readies on both instances.
    rdy_mode[0] = 1;
    rdy_mode[1] = 1;
    for (int p = 0; p < 30; p++) begin
      push_pkt(0, 8'($urandom), 16'($urandom_range(0, 4)));
      push_pkt(1, 8'($urandom_range(0, 5)), 16'($urandom_range(0, 4)));
    end
    run_idle("rand_drain", 5000);
    final_counts("rand");

    // Reset in the middle of a block burst.
    rdy_mode[0] = 0;
    rdy_mode[1] = 0;
    push_pkt(0, 8'h00, 16'd4);
    for (int c = 0; c < 50 && exp_q[0].size() > 3; c++) tick();
    chk("t6_one_block", 32'(exp_q[0].size()), 32'd3);
    rst = 1'b0;
    #1;
    check_reset("t6_async");
    model_reset();
    in_v[0] = 1'b0;
    in_d[0] = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("t6_idle", bsy[0], 1'b0);
    push_pkt(0, 8'h00, 16'd1);
    run_idle("t6_drain", 100);
    final_counts("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/query_stream_dispatcher.md
Name: query_stream_dispatcher

Overview:
Single-clock successor to the stream input handler, placed after the stream sync FIFO. It parses the synchronized stream into query-info headers and query-sequence blocks, then dispatches each query packet to one of NUM_ENGINES alignment engines. Engine selection is either round-robin or directed by a header field. The block count is exact, zero-block queries are supported, and packets aimed at a nonexistent engine are dropped and counted.

Parameters:
NUM_PES, 64, PEs per engine; block width = 2*NUM_PES bits (must be ≤ STREAM_WIDTH)
NUM_ENGINES, 4, engines served (1..256)
STREAM_WIDTH, 128, stream word width (≥ 96)
DIRECTED, 0, 0 = round-robin selection, 1 = header field [87:80] selects engine

Ports:
clk  in  1  engine clock
rst  in  1  asynchronous, active-low reset
in_valid  in  1  stream word available (sync FIFO not empty)
in_data  in  STREAM_WIDTH  stream word (FIFO dout, first-word-fall-through)
in_rdy  out  1  pop; word consumed when in_valid & in_rdy
ref_length_out  out  25  latched header [24:0]
ref_addr_out  out  25  latched header [56:32]
num_query_blocks_out  out  16  latched header [79:64]
query_info_valid_out  out  NUM_ENGINES  one-hot info valid
query_info_rdy_in  in  NUM_ENGINES  per-engine info ready
query_seq_block_out  out  2*NUM_PES  in_data[2*NUM_PES-1:0], passed through
query_seq_block_valid_out  out  NUM_ENGINES  one-hot block valid
query_seq_block_rdy_in  in  NUM_ENGINES  per-engine block ready
err_bad_engine  out  1  one-cycle pulse when a packet is dropped
drop_count  out  16  packets dropped, saturating
pkt_count  out  32  packets dispatched, wrapping
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, sel=0, rr_ptr=0, block counter=0, latched header=0, all valid vectors 0, in_rdy=0, err_bad_engine=0, both counters 0. Deassertion is used synchronously.
- States: IDLE, INFO, BLOCKS, DROP.
- IDLE:
  - in_rdy=1.
  - On accept: latch header fields.
  - DIRECTED=0: sel=rr_ptr. DIRECTED=1: sel=in_data[87:80].
  - If DIRECTED=1 and sel ≥ NUM_ENGINES: pulse err_bad_engine next cycle, increment drop_count (saturates at 0xFFFF), remaining=num_query_blocks, go to DROP (or straight to IDLE if the count is 0).
  - Otherwise go to INFO.
- INFO:
  - in_rdy=0. query_info_valid_out[sel]=1; all other bits 0. Header outputs stay stable.
  - On query_info_rdy_in[sel]: remaining=num_query_blocks.
  - If remaining=0: pkt_count+1, rr_ptr advances, go to IDLE. Otherwise go to BLOCKS.
  - Header info is valid the cycle after the header is accepted (latency 1).
- BLOCKS:
  - query_seq_block_valid_out[sel]=in_valid; in_rdy=query_seq_block_rdy_in[sel]. Combinational pass-through, zero latency.
  - Each transfer decrements remaining.
  - When the transfer with remaining=1 completes: pkt_count+1, rr_ptr advances, go to IDLE.
  - Exactly num_query_blocks blocks are forwarded per packet.
- DROP: in_rdy=1; each accepted word decrements remaining; go to IDLE when remaining reaches 0. No valid is asserted.
- rr_ptr advance: rr_ptr+1, wrapping to 0 after NUM_ENGINES-1. It advances only on packet completion, never on a drop.
- Valid stability: a valid bit, once raised, stays high with data stable until its ready. Exception: in BLOCKS, valid tracks in_valid, and the FIFO holds its data until popped.
- Ready on non-selected engines is ignored. Ready without valid has no effect.
- Only one packet is in flight at a time; a new header is not accepted until the current packet fully completes.
- Reset asserted mid-packet aborts immediately. Words remaining in the FIFO are treated as a new header after reset (the upstream FIFO is reset alongside).
- The 16-bit remaining counter handles num_query_blocks=0xFFFF without wrap.

Test Plan:
1. DIRECTED=0, NUM_ENGINES=4, four headers each with 2 blocks, all rdy=1 -> info/blocks go to engines 0,1,2,3 in order; pkt_count=4; 3 in_rdy pops per packet.
2. Header with num_query_blocks=0 -> one info handshake on engine 0, no block valid, next header goes to engine 1; pkt_count=1.
3. DIRECTED=1, header [87:80]=2, 3 blocks, query_seq_block_rdy_in[2] toggling 1,0,1,0,1 -> exactly 3 transfers; valid and data stable while rdy=0; only bit 2 ever asserted.
4. DIRECTED=1, header [87:80]=9 with NUM_ENGINES=4, 5 blocks -> 6 words popped, no valid asserted, err_bad_engine pulses once, drop_count=1; the following valid header is dispatched normally.
5. query_info_rdy_in held 0 for 10 cycles -> info valid and header outputs stable, in_rdy=0 throughout; completes on the first rdy.
6. rst pulled low mid-BLOCKS after 1 of 4 blocks -> all outputs go to reset values asynchronously; after release, state=IDLE and rr_ptr=0.
